// File: rtl/sram_arbiter_if.sv
// Requester-side bundle of the SRAM arbiter: the three request/ack
// handshakes plus the shared read-data and busy outputs.
interface sram_arbiter_if;
  logic        vid_req;
  logic [4:0]  vid_page;
  logic [13:0] vid_addr;
  logic        vid_ack;

  logic        cpu_req;
  logic        cpu_we;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;

  logic        ldr_req;
  logic        ldr_we;
  logic [18:0] ldr_addr;
  logic [7:0]  ldr_wdata;
  logic        ldr_ack;

  logic [7:0]  rd_data;
  logic        busy;

  // Requester side: drives requests, receives acks and read data.
  modport master (
    output vid_req, vid_page, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  vid_ack, cpu_ack, ldr_ack, rd_data, busy
  );

  // Arbiter side.
  modport slave (
    input  vid_req, vid_page, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output vid_ack, cpu_ack, ldr_ack, rd_data, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between video fetch, CPU and boot loader.
// Each access runs IDLE -> SETUP -> ACTIVE (ACC_CYCLES) [-> HOLD for writes]
// -> IDLE with a one-clock ack. Video > CPU > loader, except that a loader
// kept waiting for STARVE_LIMIT CPU grants is let in ahead of the CPU.
module sram_arbiter #(
  parameter int ACC_CYCLES   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  sram_arbiter_if.slave bus,
  output logic [18:0] sram_addr,
  inout  wire  [7:0]  sram_data,
  output logic        sram_we_n
);

  localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // One-hot grant encoding; bit index matches the ack vector.
  localparam logic [2:0] G_VID = 3'b001;
  localparam logic [2:0] G_CPU = 3'b010;
  localparam logic [2:0] G_LDR = 3'b100;

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [2:0]      gnt_q, gnt_d;
  logic            we_q, we_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [18:0]     addr_q, addr_d;
  logic            we_n_q, we_n_d;
  logic            drive_q, drive_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic [2:0]      ack_q, ack_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   starve_q, starve_d;

  logic [2:0]      req_v;
  logic [2:0]      req_m;
  logic [2:0]      pick;
  logic            last_beat;

  assign req_v = {bus.ldr_req, bus.cpu_req, bus.vid_req};

  // A requester being acked this cycle still has its stale req high; hide it.
  for (genvar gi = 0; gi < 3; gi++) begin : g_mask
    assign req_m[gi] = req_v[gi] & ~ack_q[gi];
  end

  // Priority pick among unmasked requests, with the loader starvation override.
  always_comb begin
    pick = '0;
    if (req_m[0])                                       pick = G_VID;
    else if (req_m[2] && (starve_q >= SW'(STARVE_LIMIT))) pick = G_LDR;
    else if (req_m[1])                                  pick = G_CPU;
    else if (req_m[2])                                  pick = G_LDR;
  end

  // Access sequencer: next state, latched request fields, read capture, acks.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    ack_d     = '0;
    last_beat = (cnt_q == CW'(ACC_CYCLES - 1));
    case (state_q)
      IDLE: begin
        if (pick != 3'b000) begin
          state_d = SETUP;
          gnt_d   = pick;
          case (pick)
            G_VID: begin
              addr_d = {bus.vid_page, bus.vid_addr};
              we_d   = 1'b0;
            end
            G_CPU: begin
              addr_d  = bus.cpu_addr;
              we_d    = bus.cpu_we;
              wdata_d = bus.cpu_wdata;
            end
            default: begin
              addr_d  = bus.ldr_addr;
              we_d    = bus.ldr_we;
              wdata_d = bus.ldr_wdata;
            end
          endcase
        end
      end
      SETUP: begin
        state_d = ACTIVE;
        cnt_d   = '0;
      end
      ACTIVE: begin
        if (last_beat) begin
          if (we_q) begin
            state_d = HOLD;
          end else begin
            state_d   = IDLE;
            rd_data_d = sram_data;
            ack_d     = gnt_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        state_d = IDLE;
        ack_d   = gnt_q;
      end
      default: state_d = IDLE;
    endcase
    // Pin controls are registered from the upcoming state so they are glitch-free.
    we_n_d  = !((state_d == ACTIVE) && we_d);
    drive_d = (state_d != IDLE) && we_d;
  end

  // Starvation counter: CPU grants seen while the loader keeps asking.
  always_comb begin
    starve_d = starve_q;
    if (!bus.ldr_req) begin
      starve_d = '0;
    end else if ((state_q == IDLE) && (pick == G_LDR)) begin
      starve_d = '0;
    end else if ((state_q == IDLE) && (pick == G_CPU) && (starve_q < SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // State and pin registers; reset drops the strobe and the data driver at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      addr_q    <= '0;
      we_n_q    <= 1'b1;
      drive_q   <= 1'b0;
      rd_data_q <= '0;
      ack_q     <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      we_n_q    <= we_n_d;
      drive_q   <= drive_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
    end
  end

  assign sram_addr   = addr_q;
  assign sram_we_n   = we_n_q;
  assign sram_data   = drive_q ? wdata_q : 8'hzz;
  assign bus.vid_ack = ack_q[0];
  assign bus.cpu_ack = ack_q[1];
  assign bus.ldr_ack = ack_q[2];
  assign bus.rd_data = rd_data_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural asynchronous SRAM.
module tb_sram_arbiter;

  logic        clk;
  logic        rst_n;
  wire  [7:0]  sram_data;
  logic [18:0] sram_addr;
  logic        sram_we_n;

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;

  sram_arbiter_if bus ();

  sram_arbiter #(.ACC_CYCLES(2), .STARVE_LIMIT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_we_n (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: latches on the rising edge of the write strobe, drives reads
  // only while an access is in flight and the bench has enabled it.
  logic [7:0] mem [logic [18:0]];
  logic       model_oe;
  logic [7:0] model_q;
  always @(posedge sram_we_n) if (rst_n === 1'b1) mem[sram_addr] = sram_data;
  always @(negedge clk) model_q = mem.exists(sram_addr) ? mem[sram_addr] : 8'h00;
  assign sram_data = (model_oe && bus.busy) ? model_q : 8'hzz;

  wire data_hiz = (sram_data === 8'hzz);

  // Acks must never overlap.
  always @(negedge clk) if ($countones({bus.vid_ack, bus.cpu_ack, bus.ldr_ack}) > 1) overlap++;

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One CPU access; latency counts the request-sampling edge as clock 1.
  task automatic run_cpu(input logic we, input logic [18:0] a, input logic [7:0] d,
                         output int lat, output int we_low, output int drv);
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_req   = 1'b1;
    lat = 0; we_low = 0; drv = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      lat++;
      if (!sram_we_n) we_low++;
      if (we && (sram_data == d)) drv++;
      if (bus.cpu_ack) break;
    end
    bus.cpu_req = 1'b0;
    $display("cpu %s addr=%05h lat=%0d we_low=%0d drv=%0d rd=%02h",
             we ? "wr" : "rd", a, lat, we_low, drv, bus.rd_data);
  endtask

  int  lat, wl, drv, n_vid, n_cpu, idle_cnt, cpu_cnt, ldr_n, first_run, second_run;
  logic seen;
  logic [18:0] cpu_start_addr;
  logic cpu_started;

  initial begin
    rst_n         = 1'b0;
    model_oe      = 1'b0;
    bus.vid_req   = 1'b1;
    bus.vid_page  = 5'h1F;
    bus.vid_addr  = 14'h0001;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 19'h0;
    bus.cpu_wdata = 8'h0;
    bus.ldr_req   = 1'b1;
    bus.ldr_we    = 1'b0;
    bus.ldr_addr  = 19'h00010;
    bus.ldr_wdata = 8'h0;

    // Reset held with every request high.
    repeat (3) step();
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_hiz", data_hiz, 1);
    chk("rst_acks", {bus.vid_ack, bus.cpu_ack, bus.ldr_ack}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_rd_data", bus.rd_data, 0);

    // Release: video must be granted first.
    rst_n = 1'b1;
    step();
    chk("rel_first_addr", sram_addr, 19'h7C001);
    chk("rel_busy", bus.busy, 1);
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    model_oe    = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.vid_ack) begin seen = 1'b1; break; end
    end
    chk("rel_vid_ack", seen, 1);
    chk("rel_cpu_ack", bus.cpu_ack, 0);
    bus.vid_req = 1'b0;
    $display("reset release: video read 7C001 acked=%0d", seen);
    step();

    // CPU write 5A to 4ABCD.
    model_oe = 1'b0;
    run_cpu(1'b1, 19'h4ABCD, 8'h5A, lat, wl, drv);
    chk("wr_latency", lat, 5);
    chk("wr_we_low_clks", wl, 2);
    chk("wr_data_clks", drv, 4);
    chk("wr_rd_data_kept", bus.rd_data, 8'h00);
    step();
    chk("wr_ack_pulse", bus.cpu_ack, 0);
    chk("wr_idle_hiz", data_hiz, 1);

    // CPU read back from the SRAM model.
    model_oe = 1'b1;
    run_cpu(1'b0, 19'h4ABCD, 8'h00, lat, wl, drv);
    chk("rd_latency", lat, 4);
    chk("rd_data", bus.rd_data, 8'h5A);
    chk("rd_we_low_clks", wl, 0);
    step();

    // Video and CPU together: video first, one IDLE cycle, then CPU.
    bus.vid_page = 5'h05;
    bus.vid_addr = 14'h1800;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 19'h4ABCD;
    bus.vid_req  = 1'b1;
    bus.cpu_req  = 1'b1;
    n_vid = 0; n_cpu = 0; idle_cnt = 0; cpu_started = 1'b0; cpu_start_addr = '0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 1) chk("prio_vid_addr", sram_addr, 19'h15800);
      if (bus.vid_ack) begin n_vid = n; bus.vid_req = 1'b0; end
      if (n_vid != 0 && n_cpu == 0 && !bus.busy && !bus.cpu_ack) idle_cnt++;
      if (n_vid != 0 && bus.busy && !cpu_started) begin
        cpu_started = 1'b1;
        cpu_start_addr = sram_addr;
      end
      if (bus.cpu_ack) begin n_cpu = n; bus.cpu_req = 1'b0; break; end
    end
    $display("priority: vid_ack@%0d cpu_ack@%0d idle=%0d", n_vid, n_cpu, idle_cnt);
    chk("prio_vid_ack_at", n_vid, 4);
    chk("prio_cpu_ack_at", n_cpu, 8);
    chk("prio_idle_cycles", idle_cnt, 1);
    chk("prio_cpu_addr", cpu_start_addr, 19'h4ABCD);
    chk("prio_cpu_rd", bus.rd_data, 8'h5A);
    step();

    // Starvation: video held alongside so the CPU is never masked against the
    // loader alone; video and CPU alternate until the loader is forced in.
    bus.vid_page = 5'h00;
    bus.vid_addr = 14'h0100;
    bus.cpu_addr = 19'h00200;
    bus.ldr_addr = 19'h00300;
    bus.ldr_we   = 1'b0;
    bus.vid_req  = 1'b1;
    bus.cpu_req  = 1'b1;
    bus.ldr_req  = 1'b1;
    cpu_cnt = 0; ldr_n = 0; first_run = -1; second_run = -1;
    for (int i = 0; i < 600; i++) begin
      step();
      if (bus.cpu_ack) cpu_cnt++;
      if (bus.ldr_ack) begin
        ldr_n++;
        $display("starve: loader grant %0d after %0d cpu grants", ldr_n, cpu_cnt);
        if (ldr_n == 1) begin
          first_run = cpu_cnt;
          cpu_cnt = 0;
        end else begin
          second_run = cpu_cnt;
          break;
        end
      end
    end
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    chk("starve_first", first_run, 8);
    chk("starve_after_clear", second_run, 8);
    for (int i = 0; i < 20; i++) begin
      step();
      if (!bus.busy && !bus.vid_ack && !bus.cpu_ack && !bus.ldr_ack) break;
    end

    // Masking: cpu_req stays high through the edge that ends its ack cycle.
    bus.cpu_addr = 19'h4ABCD;
    bus.cpu_we   = 1'b0;
    bus.cpu_req  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.cpu_ack) begin seen = 1'b1; break; end
    end
    chk("mask_first_ack", seen, 1);
    step();
    chk("mask_no_regrant", bus.busy, 0);
    bus.cpu_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.busy || bus.cpu_ack) seen = 1'b1;
    end
    chk("mask_quiet", seen, 0);
    $display("mask: single cpu access, no regrant");

    // Abort: reset pulse in the middle of a write's ACTIVE phase.
    model_oe      = 1'b0;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 19'h00100;
    bus.cpu_wdata = 8'hA5;
    bus.cpu_req   = 1'b1;
    step();
    step();
    chk("abort_in_active", sram_we_n, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_we_n_async", sram_we_n, 1);
    chk("abort_hiz", data_hiz, 1);
    chk("abort_busy", bus.busy, 0);
    bus.cpu_req = 1'b0;
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.cpu_ack || bus.busy) seen = 1'b1;
    end
    chk("abort_no_ack", seen, 0);
    $display("abort: write to 00100 cut by reset");

    chk("ack_exclusive", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
